// File: rtl/voice_mixer.sv
// voice_mixer: four-voice gain/mix engine with ready/valid output; define VOICE_MIXER_SAT_EN to clamp the mix instead of wrapping.
module voice_mixer (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        sample_tick,
  input  logic [3:0]  voice_en,
  input  logic [15:0] voice_sample_0,
  input  logic [15:0] voice_sample_1,
  input  logic [15:0] voice_sample_2,
  input  logic [15:0] voice_sample_3,
  input  logic [15:0] keyvol_0,
  input  logic [15:0] keyvol_1,
  input  logic [15:0] keyvol_2,
  input  logic [15:0] keyvol_3,
  output logic [15:0] mix_data,
  output logic        mix_valid,
  input  logic        mix_ready,
  output logic        clip,
  output logic        busy,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, MAC, SAT, HOLD} state_t;
  state_t             r_state;
  logic [1:0]         r_idx;
  logic signed [18:0] r_acc;
  logic [15:0]        r_smp [4];
  logic [15:0]        r_gain [4];
  logic [3:0]         r_en;
  logic [15:0]        r_mix_data;
  logic               r_mix_valid;
  logic               r_clip;
  logic               r_overrun;
  logic [15:0]        w_smp, w_gain, w_sat;
  logic [32:0]        w_prod;
  logic signed [18:0] w_term;
  logic               w_start, w_drop, w_clip;
  assign w_smp   = r_smp[r_idx];
  assign w_gain  = r_gain[r_idx];
  // low 33 bits of the product are the same whether the operands are treated as signed or unsigned
  assign w_prod  = {{17{w_smp[15]}}, w_smp} * {17'b0, w_gain};
  assign w_term  = r_en[r_idx] ? {{2{w_prod[32]}}, w_prod[32:16]} : '0;
  assign w_start = sample_tick && (r_state == IDLE || (r_state == HOLD && mix_ready));
  assign w_drop  = sample_tick && !w_start;
`ifdef VOICE_MIXER_SAT_EN
  logic w_hi, w_lo;
  assign w_hi   = r_acc > 19'sd32767;
  assign w_lo   = r_acc < -19'sd32768;
  assign w_sat  = w_hi ? 16'h7FFF : w_lo ? 16'h8000 : r_acc[15:0];
  assign w_clip = w_hi || w_lo;
`else
  assign w_sat  = r_acc[15:0];
  assign w_clip = 1'b0;
`endif
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_mix_data  <= '0;
      r_mix_valid <= 1'b0;
      r_clip      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_drop) r_overrun <= 1'b1;
      case (r_state)
        MAC: begin
          r_acc <= r_acc + w_term;
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= SAT;
        end
        SAT: begin
          r_mix_data  <= w_sat;
          r_clip      <= w_clip;
          r_mix_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: if (mix_ready) begin
          r_mix_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: ;
      endcase
      // an accepted tick overrides the HOLD->IDLE return so back-to-back samples lose no cycle
      if (w_start) begin
        r_smp[0]  <= voice_sample_0;
        r_smp[1]  <= voice_sample_1;
        r_smp[2]  <= voice_sample_2;
        r_smp[3]  <= voice_sample_3;
        r_gain[0] <= keyvol_0;
        r_gain[1] <= keyvol_1;
        r_gain[2] <= keyvol_2;
        r_gain[3] <= keyvol_3;
        r_en      <= voice_en;
        r_acc     <= '0;
        r_idx     <= '0;
        r_state   <= MAC;
      end
    end
  end
  assign mix_data  = r_mix_data;
  assign mix_valid = r_mix_valid;
  assign clip      = r_clip;
  assign overrun   = r_overrun;
  assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: randomized scoreboard bench for voice_mixer against an arithmetic reference model.
module tb_voice_mixer;
  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic [3:0]  voice_en = '0;
  logic [15:0] vs [4];
  logic [15:0] kv [4];
  logic [15:0] mix_data;
  logic        mix_valid;
  logic        mix_ready = 1'b0;
  logic        clip, busy, overrun;
  voice_mixer dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .sample_tick(sample_tick), .voice_en(voice_en),
    .voice_sample_0(vs[0]), .voice_sample_1(vs[1]), .voice_sample_2(vs[2]), .voice_sample_3(vs[3]),
    .keyvol_0(kv[0]), .keyvol_1(kv[1]), .keyvol_2(kv[2]), .keyvol_3(kv[3]),
    .mix_data(mix_data), .mix_valid(mix_valid), .mix_ready(mix_ready),
    .clip(clip), .busy(busy), .overrun(overrun)
  );
  always #5 clk_clk = ~clk_clk;
  typedef struct {logic [15:0] data; logic clip; int acc_cyc;} exp_t;
  exp_t sb [$];
  int   checks = 0, failures = 0, cyc = 0, m_cnt = 0;
  bit   m_busy = 0, m_ovr = 0, mon_on = 0, prev_valid = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  // reference: exact integer product, floor division by 65536, then clamp or wrap
  function automatic exp_t model_mix();
    exp_t  e;
    longint sum = 0;
    for (int n = 0; n < 4; n++)
      if (voice_en[n]) sum += (longint'($signed(vs[n])) * longint'(kv[n])) >>> 16;
    e.clip = 1'b0;
    e.data = sum[15:0];
`ifdef VOICE_MIXER_SAT_EN
    if (sum > 32767) begin e.data = 16'h7FFF; e.clip = 1'b1; end
    if (sum < -32768) begin e.data = 16'h8000; e.clip = 1'b1; end
`endif
    e.acc_cyc = cyc;
    return e;
  endfunction
  task automatic step(input logic tk, input logic rdy);
    bit hs, acc;
    sample_tick = tk;
    mix_ready   = rdy;
    @(posedge clk_clk);
    #2;
    if (reset_reset) begin
      m_busy = 0; m_ovr = 0; m_cnt = 0;
      sb.delete();
    end else begin
      hs  = m_busy && m_cnt >= 5 && rdy;
      acc = tk && (!m_busy || hs);
      if (tk && !acc) m_ovr = 1;
      if (acc) begin
        sb.push_back(model_mix());
        m_busy = 1; m_cnt = 0;
      end else if (hs) m_busy = 0;
      else if (m_busy) m_cnt++;
    end
  endtask
  task automatic setv(input logic [3:0] en, input logic [15:0] s0, s1, s2, s3, k0, k1, k2, k3);
    voice_en = en;
    vs[0] = s0; vs[1] = s1; vs[2] = s2; vs[3] = s3;
    kv[0] = k0; kv[1] = k1; kv[2] = k2; kv[3] = k3;
  endtask
  task automatic do_reset();
    reset_reset = 1'b1;
    step(1'b1, 1'b1);
    reset_reset = 1'b0;
    chk("rst_data", mix_data, 16'h0000);
    chk("rst_clip", clip, 1'b0);
    chk("rst_valid", mix_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
  endtask
  always @(negedge clk_clk) if (mon_on) begin
    chk("busy", busy, m_busy);
    chk("overrun", overrun, m_ovr);
    chk("mix_valid", mix_valid, m_busy && m_cnt >= 5);
    if (mix_valid) begin
      chk("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        if (!prev_valid) chk("latency", cyc - sb[0].acc_cyc, 5);
        chk("mix_data", mix_data, sb[0].data);
        chk("clip", clip, sb[0].clip);
        if (mix_ready && !reset_reset) void'(sb.pop_front());
      end
    end
    prev_valid = mix_valid;
  end
  initial begin
    setv(4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1'b1, 1'b0);
    reset_reset = 1'b0;
    chk("init_data", mix_data, 16'h0000);
    chk("init_valid", mix_valid, 1'b0);
    chk("init_busy", busy, 1'b0);
    mon_on = 1;
    // single voice, ready held high
    setv(4'b0001, 16'h4000, 0, 0, 0, 16'hFFFF, 0, 0, 0);
    step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    // full-scale overflow on all voices
    setv(4'b1111, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    // floor rounding of negative products
    setv(4'b0011, 16'h8000, 16'hFFFF, 16'h1234, 16'h1234, 16'h8000, 16'h0001, 16'hFFFF, 16'hFFFF);
    step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    // backpressure with a dropped tick in HOLD
    setv(4'b0101, 16'h1111, 16'h2222, 16'hC000, 16'h3333, 16'h8000, 16'h4000, 16'h2000, 16'h1000);
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0);
    chk("bp_overrun", overrun, 1'b1);
    chk("bp_busy", busy, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("bp_idle", busy, 1'b0);
    // back-to-back: second tick on the handshake edge
    do_reset();
    setv(4'b1000, 0, 0, 0, 16'h9000, 0, 0, 0, 16'hF000);
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    setv(4'b0110, 0, 16'h7000, 16'h6000, 0, 0, 16'hFFFF, 16'hFFFF, 0);
    step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("b2b_overrun", overrun, 1'b0);
    // reset in MAC at idx=2, then snapshot isolation
    setv(4'b0001, 16'h5555, 0, 0, 0, 16'hFFFF, 0, 0, 0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    reset_reset = 1'b1;
    step(1'b1, 1'b1);
    reset_reset = 1'b0;
    chk("midrst_valid", mix_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_overrun", overrun, 1'b0);
    setv(4'b1001, 16'h2000, 0, 0, 16'hE000, 16'h8000, 0, 0, 16'hFFFF);
    step(1'b1, 1'b1);
    vs[0] = 16'h7FFF; vs[3] = 16'h0001;
    step(1'b0, 1'b1);
    vs[0] = 16'h8000; kv[0] = 16'h0000;
    repeat (8) step(1'b0, 1'b1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 4; n++) begin
        vs[n] = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000) : 16'($urandom);
        kv[n] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      end
      voice_en = 4'($urandom);
      reset_reset = ($urandom_range(0, 149) == 0);
      step($urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end
    reset_reset = 1'b0;
    repeat (12) step(1'b0, 1'b1);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
